writeback_arbiter: RTL and testbench

Serializes register write-backs from the four result producers (misc, alu, mem, fpu) onto the register manager's single shared write port. Each source gets a one-entry holding slot with a valid/ready handshake. Slots drain under round-robin arbitration. The block blocks write-after-write reordering to the same register and exports per-register pending bits so issue logic can stall dependent reads. It sits between the execution units and register_manager.

---
 rtl/writeback_arbiter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Serializes write-backs from four result producers (misc, alu,
//               mem, fpu) onto the register manager's single write port.
//               Each source has a one-entry holding slot drained round-robin.
//               Same-register writes are ordered, and per-register pending
//               bits are exported for issue-side hazard stalls.
//               Optional feature macro: WB_BYPASS_EN (same-cycle commit of an
//               incoming request when every slot is empty).
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              misc_valid,
    output logic              misc_ready,
    input  logic [ADDR_W-1:0] misc_addr,
    input  logic [DATA_W-1:0] misc_data,
    input  logic              misc_float,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_float,

    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_float,

    input  logic              fpu_valid,
    output logic              fpu_ready,
    input  logic [ADDR_W-1:0] fpu_addr,
    input  logic [DATA_W-1:0] fpu_data,
    input  logic              fpu_float,

    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_float,

    output logic [31:0]       busy_int,
    output logic [31:0]       busy_float
);

    localparam int c_num_src = 4;

    // Source inputs gathered into index-ordered arrays (misc=0 .. fpu=3)
    logic              w_in_valid [c_num_src];
    logic [ADDR_W-1:0] w_in_addr  [c_num_src];
    logic [DATA_W-1:0] w_in_data  [c_num_src];
    logic              w_in_flt   [c_num_src];

    // Holding slots
    logic [c_num_src-1:0] r_occ;
    logic [ADDR_W-1:0]    r_addr [c_num_src];
    logic [DATA_W-1:0]    r_data [c_num_src];
    logic                 r_flt  [c_num_src];

    logic [1:0]           r_last_grant;
    logic [31:0]          r_busy_int;
    logic [31:0]          r_busy_float;

    logic                 w_slot_grant_valid;
    logic [1:0]           w_slot_grant_idx;
    logic [c_num_src-1:0] w_slot_commit;
    logic [c_num_src-1:0] w_ready;
    logic [c_num_src-1:0] w_accept;
    logic [c_num_src-1:0] w_load;
    logic                 w_commit_valid;
    logic [1:0]           w_commit_idx;
    logic [31:0]          w_busy_int_nxt;
    logic [31:0]          w_busy_float_nxt;

    assign w_in_valid[0] = misc_valid;
    assign w_in_addr[0]  = misc_addr;
    assign w_in_data[0]  = misc_data;
    assign w_in_flt[0]   = misc_float;
    assign w_in_valid[1] = alu_valid;
    assign w_in_addr[1]  = alu_addr;
    assign w_in_data[1]  = alu_data;
    assign w_in_flt[1]   = alu_float;
    assign w_in_valid[2] = mem_valid;
    assign w_in_addr[2]  = mem_addr;
    assign w_in_data[2]  = mem_data;
    assign w_in_flt[2]   = mem_float;
    assign w_in_valid[3] = fpu_valid;
    assign w_in_addr[3]  = fpu_addr;
    assign w_in_data[3]  = fpu_data;
    assign w_in_flt[3]   = fpu_float;

    assign misc_ready = w_ready[0];
    assign alu_ready  = w_ready[1];
    assign mem_ready  = w_ready[2];
    assign fpu_ready  = w_ready[3];

    assign busy_int   = r_busy_int;
    assign busy_float = r_busy_float;

    // Round-robin pick among occupied slots, starting after the last grant
    always_comb begin : p_slot_grant
        logic [1:0] v_cand;
        v_cand             = 2'd0;
        w_slot_grant_valid = 1'b0;
        w_slot_grant_idx   = 2'd0;
        for (int k = 1; k <= c_num_src; k++) begin
            v_cand = r_last_grant + 2'(k);
            if (!w_slot_grant_valid && r_occ[v_cand]) begin
                w_slot_grant_valid = 1'b1;
                w_slot_grant_idx   = v_cand;
            end
        end
    end

    // One-hot view of which slot drains this cycle
    always_comb begin
        w_slot_commit = '0;
        if (w_slot_grant_valid) begin
            w_slot_commit[w_slot_grant_idx] = 1'b1;
        end
    end

    // Ready: own slot free (or freeing), no pending same-key write elsewhere,
    // and no lower-index source presenting the same key this cycle
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < c_num_src; i++) begin
            w_ready[i] = !reset && (!r_occ[i] || w_slot_commit[i]);
            for (int j = 0; j < c_num_src; j++) begin
                if (j != i && r_occ[j] && !w_slot_commit[j] &&
                    r_flt[j] == w_in_flt[i] && r_addr[j] == w_in_addr[i]) begin
                    w_ready[i] = 1'b0;
                end
                if (j < i && w_in_valid[j] &&
                    w_in_flt[j] == w_in_flt[i] && w_in_addr[j] == w_in_addr[i]) begin
                    w_ready[i] = 1'b0;
                end
            end
        end
    end

    assign w_accept = w_ready & {w_in_valid[3], w_in_valid[2], w_in_valid[1], w_in_valid[0]};

`ifdef WB_BYPASS_EN
    logic       w_byp_valid;
    logic [1:0] w_byp_idx;

    // Round-robin pick among accepted requests when every slot is empty
    always_comb begin : p_byp_grant
        logic [1:0] v_cand;
        v_cand      = 2'd0;
        w_byp_valid = 1'b0;
        w_byp_idx   = 2'd0;
        if (r_occ == '0) begin
            for (int k = 1; k <= c_num_src; k++) begin
                v_cand = r_last_grant + 2'(k);
                if (!w_byp_valid && w_accept[v_cand]) begin
                    w_byp_valid = 1'b1;
                    w_byp_idx   = v_cand;
                end
            end
        end
    end

    // The bypassed winner is committed directly and never occupies its slot
    always_comb begin
        w_load = w_accept;
        if (w_byp_valid) begin
            w_load[w_byp_idx] = 1'b0;
        end
    end

    // Commit port: registered slot first, otherwise the bypassed request
    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_write_float  = 1'b0;
        w_commit_valid  = 1'b0;
        w_commit_idx    = 2'd0;
        if (!reset) begin
            if (w_slot_grant_valid) begin
                w_commit_valid  = 1'b1;
                w_commit_idx    = w_slot_grant_idx;
                rf_write_enable = 1'b1;
                rf_write_addr   = r_addr[w_slot_grant_idx];
                rf_write_data   = r_data[w_slot_grant_idx];
                rf_write_float  = r_flt[w_slot_grant_idx];
            end else if (w_byp_valid) begin
                w_commit_valid  = 1'b1;
                w_commit_idx    = w_byp_idx;
                rf_write_enable = 1'b1;
                rf_write_addr   = w_in_addr[w_byp_idx];
                rf_write_data   = w_in_data[w_byp_idx];
                rf_write_float  = w_in_flt[w_byp_idx];
            end
        end
    end
`else
    assign w_load = w_accept;

    // Commit port driven purely from registered slot state
    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_write_float  = 1'b0;
        w_commit_valid  = 1'b0;
        w_commit_idx    = 2'd0;
        if (!reset && w_slot_grant_valid) begin
            w_commit_valid  = 1'b1;
            w_commit_idx    = w_slot_grant_idx;
            rf_write_enable = 1'b1;
            rf_write_addr   = r_addr[w_slot_grant_idx];
            rf_write_data   = r_data[w_slot_grant_idx];
            rf_write_float  = r_flt[w_slot_grant_idx];
        end
    end
`endif

    // Pending bits: clear the draining slot's key, then set accepted keys
    // so a same-register set and clear in one cycle leaves the bit set
    always_comb begin
        w_busy_int_nxt   = r_busy_int;
        w_busy_float_nxt = r_busy_float;
        if (w_slot_grant_valid) begin
            if (r_flt[w_slot_grant_idx]) begin
                w_busy_float_nxt[r_addr[w_slot_grant_idx]] = 1'b0;
            end else begin
                w_busy_int_nxt[r_addr[w_slot_grant_idx]] = 1'b0;
            end
        end
        for (int i = 0; i < c_num_src; i++) begin
            if (w_load[i]) begin
                if (w_in_flt[i]) begin
                    w_busy_float_nxt[w_in_addr[i]] = 1'b1;
                end else begin
                    w_busy_int_nxt[w_in_addr[i]] = 1'b1;
                end
            end
        end
    end

    // Per-source holding slot: load on accept, empty on commit
    generate
        for (genvar g = 0; g < c_num_src; g++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_occ[g]  <= 1'b0;
                    r_addr[g] <= '0;
                    r_data[g] <= '0;
                    r_flt[g]  <= 1'b0;
                end else if (w_load[g]) begin
                    r_occ[g]  <= 1'b1;
                    r_addr[g] <= w_in_addr[g];
                    r_data[g] <= w_in_data[g];
                    r_flt[g]  <= w_in_flt[g];
                end else if (w_slot_commit[g]) begin
                    r_occ[g]  <= 1'b0;
                end
            end
        end
    endgenerate

    // Arbitration pointer and pending-bit registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 2'd3;
            r_busy_int   <= '0;
            r_busy_float <= '0;
        end else begin
            if (w_commit_valid) begin
                r_last_grant <= w_commit_idx;
            end
            r_busy_int   <= w_busy_int_nxt;
            r_busy_float <= w_busy_float_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed self-checking bench for writeback_arbiter.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        misc_valid, alu_valid, mem_valid, fpu_valid;
    logic        misc_ready, alu_ready, mem_ready, fpu_ready;
    logic [4:0]  misc_addr, alu_addr, mem_addr, fpu_addr;
    logic [31:0] misc_data, alu_data, mem_data, fpu_data;
    logic        misc_float, alu_float, mem_float, fpu_float;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_write_float;
    logic [31:0] busy_int, busy_float;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .misc_valid(misc_valid), .misc_ready(misc_ready), .misc_addr(misc_addr),
        .misc_data(misc_data), .misc_float(misc_float),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_float(alu_float),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_float(mem_float),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr),
        .fpu_data(fpu_data), .fpu_float(fpu_float),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_write_float(rf_write_float),
        .busy_int(busy_int), .busy_float(busy_float)
    );

    task automatic idle();
        misc_valid = 0; misc_addr = 0; misc_data = 0; misc_float = 0;
        alu_valid  = 0; alu_addr  = 0; alu_data  = 0; alu_float  = 0;
        mem_valid  = 0; mem_addr  = 0; mem_data  = 0; mem_float  = 0;
        fpu_valid  = 0; fpu_addr  = 0; fpu_data  = 0; fpu_float  = 0;
    endtask

    task automatic drive(input int src, input logic [4:0] a, input logic [31:0] d, input logic f);
        case (src)
            0: begin misc_valid = 1; misc_addr = a; misc_data = d; misc_float = f; end
            1: begin alu_valid  = 1; alu_addr  = a; alu_data  = d; alu_float  = f; end
            2: begin mem_valid  = 1; mem_addr  = a; mem_data  = d; mem_float  = f; end
            default: begin fpu_valid = 1; fpu_addr = a; fpu_data = d; fpu_float = f; end
        endcase
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        drive(0, 5'd1, 32'd5, 1'b0);
        next_cycle();
        @(negedge clk);
        checks++; if (misc_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%0b expected=0", misc_ready); end
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we actual=%0b expected=0", rf_write_enable); end
        checks++; if (busy_int !== 32'd0) begin failures++; $display("FAIL reset_busy_int actual=%h expected=0", busy_int); end
        checks++; if (busy_float !== 32'd0) begin failures++; $display("FAIL reset_busy_float actual=%h expected=0", busy_float); end
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        checks++; if ({misc_ready, alu_ready, mem_ready, fpu_ready} !== 4'b1111) begin failures++; $display("FAIL idle_ready actual=%b expected=1111", {misc_ready, alu_ready, mem_ready, fpu_ready}); end
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL idle_we actual=%0b expected=0", rf_write_enable); end
        checks++; if ({rf_write_addr, rf_write_data, rf_write_float} !== 38'd0) begin failures++; $display("FAIL idle_port actual=%h/%h/%0b expected=0", rf_write_addr, rf_write_data, rf_write_float); end
    endtask

`ifndef WB_BYPASS_EN
    task automatic test_single();
        apply_reset();
        drive(1, 5'd4, 32'd8, 1'b0);
        @(negedge clk);
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready actual=%0b expected=1", alu_ready); end
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL single_we_early actual=%0b expected=0", rf_write_enable); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (busy_int !== 32'h10) begin failures++; $display("FAIL single_busy actual=%h expected=10", busy_int); end
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, 5'd4, 32'd8, 1'b0}) begin failures++; $display("FAIL single_commit actual=%0b/%0d/%0d/%0b expected=1/4/8/0", rf_write_enable, rf_write_addr, rf_write_data, rf_write_float); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy_int !== 32'h0) begin failures++; $display("FAIL single_busy_clr actual=%h expected=0", busy_int); end
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL single_we_after actual=%0b expected=0", rf_write_enable); end
    endtask

    task automatic test_all_four();
        logic [4:0]  ea [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [31:0] ed [4] = '{32'd16, 32'd8, 32'd42, 32'd92};
        logic        ef [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ebi [4] = '{32'h0E, 32'h0C, 32'h08, 32'h00};
        logic [31:0] ebf [4] = '{32'h10, 32'h10, 32'h10, 32'h10};
        apply_reset();
        drive(0, 5'd1, 32'd16, 1'b0);
        drive(1, 5'd2, 32'd8, 1'b0);
        drive(2, 5'd3, 32'd42, 1'b0);
        drive(3, 5'd4, 32'd92, 1'b1);
        @(negedge clk);
        checks++; if ({misc_ready, alu_ready, mem_ready, fpu_ready} !== 4'b1111) begin failures++; $display("FAIL all4_ready actual=%b expected=1111", {misc_ready, alu_ready, mem_ready, fpu_ready}); end
        next_cycle();
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, ea[k], ed[k], ef[k]}) begin failures++; $display("FAIL all4_commit%0d actual=%0b/%0d/%0d/%0b expected=1/%0d/%0d/%0b", k, rf_write_enable, rf_write_addr, rf_write_data, rf_write_float, ea[k], ed[k], ef[k]); end
            checks++; if (busy_int !== ebi[k]) begin failures++; $display("FAIL all4_busy_int%0d actual=%h expected=%h", k, busy_int, ebi[k]); end
            checks++; if (busy_float !== ebf[k]) begin failures++; $display("FAIL all4_busy_float%0d actual=%h expected=%h", k, busy_float, ebf[k]); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({rf_write_enable, busy_int, busy_float} !== 65'd0) begin failures++; $display("FAIL all4_drained actual=%0b/%h/%h expected=0/0/0", rf_write_enable, busy_int, busy_float); end
    endtask

    task automatic test_collision();
        apply_reset();
        drive(1, 5'd4, 32'd92, 1'b0);
        drive(2, 5'd4, 32'd3, 1'b0);
        drive(3, 5'd4, 32'd30, 1'b1);
        @(negedge clk);
        checks++; if ({alu_ready, mem_ready, fpu_ready} !== 3'b101) begin failures++; $display("FAIL coll_ready actual=%b expected=101", {alu_ready, mem_ready, fpu_ready}); end
        next_cycle();
        alu_valid = 0;
        fpu_valid = 0;
        @(negedge clk);
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, 5'd4, 32'd92, 1'b0}) begin failures++; $display("FAIL coll_commit_alu actual=%0b/%0d/%0d/%0b expected=1/4/92/0", rf_write_enable, rf_write_addr, rf_write_data, rf_write_float); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL coll_mem_ready actual=%0b expected=1", mem_ready); end
        next_cycle();
        mem_valid = 0;
        @(negedge clk);
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, 5'd4, 32'd3, 1'b0}) begin failures++; $display("FAIL coll_commit_mem actual=%0b/%0d/%0d/%0b expected=1/4/3/0", rf_write_enable, rf_write_addr, rf_write_data, rf_write_float); end
        checks++; if ({busy_int, busy_float} !== {32'h10, 32'h10}) begin failures++; $display("FAIL coll_busy actual=%h/%h expected=10/10", busy_int, busy_float); end
        next_cycle();
        @(negedge clk);
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, 5'd4, 32'd30, 1'b1}) begin failures++; $display("FAIL coll_commit_fpu actual=%0b/%0d/%0d/%0b expected=1/4/30/1", rf_write_enable, rf_write_addr, rf_write_data, rf_write_float); end
        checks++; if ({busy_int, busy_float} !== {32'h0, 32'h10}) begin failures++; $display("FAIL coll_busy2 actual=%h/%h expected=0/10", busy_int, busy_float); end
        next_cycle();
        @(negedge clk);
        checks++; if ({rf_write_enable, busy_int, busy_float} !== 65'd0) begin failures++; $display("FAIL coll_drained actual=%0b/%h/%h expected=0/0/0", rf_write_enable, busy_int, busy_float); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed [3] = '{32'd29, 32'd30, 32'd31};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k < 3) drive(1, 5'(5 + k), ed[k], 1'b0);
            @(negedge clk);
            if (k < 3) begin
                checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d actual=%0b expected=1", k, alu_ready); end
            end
            if (k == 0) begin
                checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL b2b_we0 actual=%0b expected=0", rf_write_enable); end
            end else begin
                checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 5'(4 + k), ed[k-1]}) begin failures++; $display("FAIL b2b_commit%0d actual=%0b/%0d/%0d expected=1/%0d/%0d", k, rf_write_enable, rf_write_addr, rf_write_data, 4 + k, ed[k-1]); end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL b2b_we_end actual=%0b expected=0", rf_write_enable); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(0, 5'd1, 32'd11, 1'b0);
        drive(1, 5'd2, 32'd22, 1'b0);
        drive(2, 5'd3, 32'd33, 1'b1);
        next_cycle();
        idle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL rmid_we_in_reset actual=%0b expected=0", rf_write_enable); end
        checks++; if ({misc_ready, alu_ready, mem_ready, fpu_ready} !== 4'b0000) begin failures++; $display("FAIL rmid_ready actual=%b expected=0000", {misc_ready, alu_ready, mem_ready, fpu_ready}); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy_int, busy_float} !== 64'd0) begin failures++; $display("FAIL rmid_busy actual=%h/%h expected=0/0", busy_int, busy_float); end
        checks++; if ({rf_write_addr, rf_write_data, rf_write_float} !== 38'd0) begin failures++; $display("FAIL rmid_port actual=%h/%h/%0b expected=0", rf_write_addr, rf_write_data, rf_write_float); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL rmid_we%0d actual=%0b expected=0", k, rf_write_enable); end
            next_cycle();
            @(negedge clk);
        end
    endtask
`else
    task automatic test_bypass();
        apply_reset();
        drive(0, 5'd9, 32'd7, 1'b0);
        drive(1, 5'd10, 32'd5, 1'b0);
        @(negedge clk);
        checks++; if ({misc_ready, alu_ready} !== 2'b11) begin failures++; $display("FAIL byp_ready actual=%b expected=11", {misc_ready, alu_ready}); end
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data, rf_write_float} !== {1'b1, 5'd9, 32'd7, 1'b0}) begin failures++; $display("FAIL byp_commit actual=%0b/%0d/%0d/%0b expected=1/9/7/0", rf_write_enable, rf_write_addr, rf_write_data, rf_write_float); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (busy_int !== 32'h400) begin failures++; $display("FAIL byp_busy actual=%h expected=400", busy_int); end
        checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 5'd10, 32'd5}) begin failures++; $display("FAIL byp_slot_commit actual=%0b/%0d/%0d expected=1/10/5", rf_write_enable, rf_write_addr, rf_write_data); end
        next_cycle();
        @(negedge clk);
        checks++; if ({rf_write_enable, busy_int} !== 33'd0) begin failures++; $display("FAIL byp_drained actual=%0b/%h expected=0/0", rf_write_enable, busy_int); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef WB_BYPASS_EN
        test_single();
        test_all_four();
        test_collision();
        test_back_to_back();
        test_reset_mid();
`else
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
